// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter that shares one DATAWIDTH-bit register among NREQ requesters, with per-requester lock.
// Optional lock timeout (MAX_HOLD consecutive locked captures) is enabled by defining REG_ARB_TIMEOUT_EN.
module reg_rr_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*DATAWIDTH-1:0] d,
  output logic [NREQ-1:0]           gnt,
  output logic [DATAWIDTH-1:0]      q,
  output logic                      q_valid,
  output logic [IDW-1:0]            q_id
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [IDW-1:0]       last_owner_r;
  logic                 win_s;
  logic [IDW-1:0]       win_idx_s;
  logic [IDW-1:0]       cand_s;
  logic [NREQ-1:0]      gnt_next_s;
  logic [DATAWIDTH-1:0] d_arr_s [NREQ];

`ifdef REG_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt_r;
  logic [HCW-1:0] hold_next_s;
`endif

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign d_arr_s[k] = d[k*DATAWIDTH +: DATAWIDTH];
  end

  // Winner selection: rotating search after the last owner in IDLE, owner only in LOCKED.
  always_comb begin
    int cand_v;
    win_s     = 1'b0;
    win_idx_s = {IDW{1'b0}};
    cand_s    = {IDW{1'b0}};
    cand_v    = 0;
    if (state_r == LOCKED) begin
      win_s     = req[last_owner_r];
      win_idx_s = last_owner_r;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cand_v = int'(last_owner_r) + 1 + i;
        if (cand_v >= NREQ) begin
          cand_v = cand_v - NREQ;
        end else begin
          cand_v = cand_v;
        end
        cand_s = IDW'(cand_v);
        if (!win_s && req[cand_s]) begin
          win_s     = 1'b1;
          win_idx_s = cand_s;
        end else begin
          win_s = win_s;
        end
      end
    end
  end

  // One-hot grant decode of the winner.
  always_comb begin
    gnt_next_s = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      gnt_next_s[k] = win_s && (win_idx_s == IDW'(k));
    end
  end

  // Next-state logic for the ownership FSM.
  always_comb begin
    state_next_s = state_r;
`ifdef REG_ARB_TIMEOUT_EN
    hold_next_s  = hold_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (win_s && lock[win_idx_s]) begin
          state_next_s = LOCKED;
`ifdef REG_ARB_TIMEOUT_EN
          hold_next_s  = HCW'(1);
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCKED: begin
        if (win_s && lock[last_owner_r]) begin
          state_next_s = LOCKED;
`ifdef REG_ARB_TIMEOUT_EN
          hold_next_s  = hold_cnt_r + HCW'(1);
          // Reaching MAX_HOLD releases ownership even if lock stays high.
          if (hold_cnt_r >= HCW'(MAX_HOLD - 1)) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = LOCKED;
          end
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered capture outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_owner_r <= IDW'(NREQ - 1);
      gnt          <= {NREQ{1'b0}};
      q            <= {DATAWIDTH{1'b0}};
      q_valid      <= 1'b0;
      q_id         <= {IDW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (win_s) begin
        gnt          <= gnt_next_s;
        q            <= d_arr_s[win_idx_s];
        q_valid      <= 1'b1;
        q_id         <= win_idx_s;
        last_owner_r <= win_idx_s;
      end else begin
        gnt     <= {NREQ{1'b0}};
        q_valid <= 1'b0;
      end
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  // Consecutive locked-capture counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r <= {HCW{1'b0}};
    end else begin
      hold_cnt_r <= hold_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Self-checking bench for reg_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_reg_rr_arbiter;
  localparam int DW       = 32;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     lock;
  logic [NREQ*DW-1:0]  d;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       q;
  logic                q_valid;
  logic [IDW-1:0]      q_id;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: owner is -1 when nobody holds the register.
  int              m_last;
  int              m_owner;
  int              m_hold;
  logic [NREQ-1:0] e_gnt;
  logic [DW-1:0]   e_q;
  logic            e_valid;
  logic [IDW-1:0]  e_id;

  reg_rr_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .d(d),
    .gnt(gnt), .q(q), .q_valid(q_valid), .q_id(q_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_owner = -1;
    m_hold  = 0;
    e_gnt   = '0;
    e_q     = '0;
    e_valid = 1'b0;
    e_id    = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs currently applied.
  task automatic model_edge();
    int w;
    w = -1;
    if (m_owner < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_last + 1 + i) % NREQ;
        if (w < 0 && req[k]) w = k;
      end
    end else if (req[m_owner]) begin
      w = m_owner;
    end
    if (w >= 0) begin
      e_gnt   = NREQ'(1) << w;
      e_q     = d[w*DW +: DW];
      e_valid = 1'b1;
      e_id    = IDW'(w);
      if (m_owner < 0) begin
        if (lock[w]) begin
          m_owner = w;
          m_hold  = 1;
        end
      end else if (lock[w]) begin
        m_hold++;
`ifdef REG_ARB_TIMEOUT_EN
        if (m_hold >= MAX_HOLD) m_owner = -1;
`endif
      end else begin
        m_owner = -1;
      end
      m_last = w;
    end else begin
      e_gnt   = '0;
      e_valid = 1'b0;
      m_owner = -1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_gnt"},    64'(gnt),     64'(e_gnt));
    chk({tag, "_q"},      64'(q),       64'(e_q));
    chk({tag, "_valid"},  64'(q_valid), 64'(e_valid));
    chk({tag, "_id"},     64'(q_id),    64'(e_id));
    chk({tag, "_onehot"}, 64'($onehot0(gnt)), 64'(1));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, 64'(gnt),     64'(0));
    chk({tag, "_q0"},   64'(q),       64'(0));
    chk({tag, "_v0"},   64'(q_valid), 64'(0));
    chk({tag, "_id0"},  64'(q_id),    64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_zero(tag);
    #2;
    rst = 1'b1;
  endtask

  task automatic set_d(input int k, input logic [DW-1:0] v);
    d[k*DW +: DW] = v;
  endtask

  initial begin
    int g1;
    rst  = 1'b0;
    req  = '0;
    lock = '0;
    d    = '0;
    model_reset();

    // Reset held for 100 ns with no requests.
    #3;
    chk_zero("rst_during");
    #97;
    chk_zero("rst_late");
    rst = 1'b1;
    step("idle_after_rst");
    chk_zero("idle_after_rst");

    // Single transfer from requester 2.
    req = 4'b0100;
    for (int k = 0; k < NREQ; k++) set_d(k, $urandom);
    set_d(2, 32'h1234);
    step("single");
    chk("single_gnt", 64'(gnt), 64'h4);
    chk("single_q",   64'(q),   64'h1234);
    chk("single_id",  64'(q_id), 64'd2);
    chk("single_v",   64'(q_valid), 64'd1);
    req = 4'b0000;
    step("single_after");
    chk("single_after_v", 64'(q_valid), 64'd0);
    chk("single_after_q", 64'(q), 64'h1234);

    // All requesting: strict rotation from requester 0 after reset.
    do_reset("rr_rst");
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_d(k, DW'(k + 10));
    for (int i = 0; i < 6; i++) begin
      step("rr");
      chk("rr_id", 64'(q_id), 64'(i % 4));
      chk("rr_q",  64'(q),    64'(10 + i % 4));
    end

    // Requester 0 locked for five edges while requester 1 waits.
    do_reset("lk_rst");
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_d(0, $urandom);
      step("lk");
      chk("lk_gnt", 64'(gnt), 64'h1);
    end
    lock = 4'b0000;
    step("lk_final");
    chk("lk_final_gnt", 64'(gnt), 64'h1);
    step("lk_next");
    chk("lk_next_gnt", 64'(gnt), 64'h2);

    // Requester 0 holds lock indefinitely with requester 1 pending.
    do_reset("hold_rst");
    req  = 4'b0011;
    lock = 4'b0001;
    g1   = 0;
    for (int i = 0; i < 50; i++) begin
      step("hold");
      if (gnt[1]) g1++;
`ifdef REG_ARB_TIMEOUT_EN
      chk("hold_gnt", 64'(gnt), (i % (MAX_HOLD + 1) == MAX_HOLD) ? 64'h2 : 64'h1);
`endif
    end
`ifdef REG_ARB_TIMEOUT_EN
    chk("hold_g1_count", 64'(g1), 64'(50 / (MAX_HOLD + 1)));
`else
    chk("hold_g1_count", 64'(g1), 64'd0);
`endif

    // Asynchronous reset while LOCKED, then rotation restarts at requester 0.
    do_reset("ar_pre");
    req  = 4'b0001;
    lock = 4'b0001;
    step("ar_lock0");
    step("ar_lock1");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_zero("ar_async");
    #2;
    rst  = 1'b1;
    req  = 4'b1111;
    lock = 4'b0000;
    step("ar_after");
    chk("ar_after_id", 64'(q_id), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req  = NREQ'($urandom);
      lock = NREQ'($urandom) | NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) set_d(k, $urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
